seg7_scan_decoder: RTL

- Receive-side counterpart of the 4-digit multiplexed 7-segment driver.
- Samples the 12-bit HEX bus, identifies the active digit, decodes the segment pattern back to a BCD nibble, and assembles a 16-bit value.
- Publishes the value only after consecutive identical frames.
- Used for self-test and loopback checking of the display path in the lift tool, and as a bench monitor.

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_pattern_decode.sv | 25 ++
 rtl/seg7_scan_decoder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment display bus: segment codes,
// digit-select positions and the scan decoder state encoding.
package seg7_pkg;

  localparam logic [11:0] SEL_MASK = 12'h9A0;

  // Select bit position per digit index (D4=0, D3=1, D2=2, D1=3).
  localparam int SEL_POS [4] = '{5, 7, 8, 11};

  localparam logic [1:0] DIG_D4 = 2'd0;
  localparam logic [1:0] DIG_D3 = 2'd1;
  localparam logic [1:0] DIG_D2 = 2'd2;
  localparam logic [1:0] DIG_D1 = 2'd3;

  // Full bus words with every select forced high, indexed by BCD digit.
  localparam logic [11:0] SEG_CODE [10] = '{
    12'hFEB, 12'h9E8, 12'hDF3, 12'hDFA, 12'hBF8,
    12'hFBA, 12'hFBB, 12'hDE8, 12'hFFB, 12'hFFA
  };

  typedef enum logic [1:0] {
    ST_SYNC,
    ST_COLLECT,
    ST_COMPARE
  } state_t;

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational segment-pattern to BCD decoder; select bits are ignored so
// the same block serves any digit position.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [11:0] pattern,
  output logic        hit,
  output logic [3:0]  nibble
);

  logic [11:0] forced;

  always_comb begin
    forced = pattern | SEL_MASK;
    hit    = 1'b0;
    nibble = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (forced == SEG_CODE[i]) begin
        hit    = 1'b1;
        nibble = 4'(i);
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers a 4-digit BCD value from a scanned 7-segment bus and publishes it
// only after several consecutive identical frames.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_FRAMES  = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] HEX,
  output logic [15:0] value,
  output logic        valid,
  output logic        new_value,
  output logic        err_pattern,
  output logic        err_select
);

  localparam int              TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TO_MAX     = TW'(TIMEOUT_CYCLES);
  localparam logic [3:0]      STABLE_MAX = 4'(STABLE_FRAMES);

  logic [11:0]   hex_q_reg;
  state_t        state_reg;
  logic [3:0]    shadow_reg [4];
  logic [3:0]    seen_reg;
  logic [15:0]   prev_reg;
  logic [3:0]    stable_reg;
  logic [TW-1:0] to_reg;

  logic [3:0]    sel_low;
  logic          multi_sel;
  logic          one_sel;
  logic [1:0]    digit;
  logic          hit;
  logic [3:0]    nib;
  logic          good;
  logic          err_pat_now;
  logic          err_any;
  logic [3:0]    seen_strobe;
  logic [3:0]    seen_next;
  logic [15:0]   frame;
  logic [3:0]    stable_next;
  logic [TW-1:0] to_next;
  logic          timeout;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sel
      assign sel_low[gi] = ~hex_q_reg[SEL_POS[gi]];
    end
  endgenerate

  seg7_pattern_decode u_decode (
    .pattern (hex_q_reg),
    .hit     (hit),
    .nibble  (nib)
  );

  always_comb begin
    multi_sel   = |(sel_low & (sel_low - 4'd1));
    one_sel     = (sel_low != 4'd0) && !multi_sel;
    digit       = onehot_to_idx(sel_low);
    good        = one_sel && hit;
    err_pat_now = one_sel && !hit;
    err_any     = multi_sel || err_pat_now;
    seen_strobe = good ? (4'd1 << digit) : 4'd0;
    seen_next   = seen_reg | seen_strobe;
    frame       = {shadow_reg[3], shadow_reg[2], shadow_reg[1], shadow_reg[0]};
    if (frame == prev_reg)
      stable_next = (stable_reg >= STABLE_MAX) ? STABLE_MAX : stable_reg + 4'd1;
    else
      stable_next = 4'd1;
    if (good)
      to_next = '0;
    else
      to_next = (to_reg == TO_MAX) ? TO_MAX : to_reg + TW'(1);
    timeout = !good && (to_next == TO_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset the bus sample to blank so the first processed word is idle.
      hex_q_reg   <= 12'hFFF;
      state_reg   <= ST_SYNC;
      for (int i = 0; i < 4; i++) shadow_reg[i] <= 4'd0;
      seen_reg    <= 4'd0;
      prev_reg    <= 16'd0;
      stable_reg  <= 4'd0;
      to_reg      <= '0;
      value       <= 16'd0;
      valid       <= 1'b0;
      new_value   <= 1'b0;
      err_pattern <= 1'b0;
      err_select  <= 1'b0;
    end else begin
      hex_q_reg   <= HEX;
      err_pattern <= err_pat_now;
      err_select  <= multi_sel;
      new_value   <= 1'b0;
      to_reg      <= to_next;

      if (good && (state_reg != ST_SYNC || digit == DIG_D4))
        shadow_reg[digit] <= nib;

      case (state_reg)
        ST_SYNC: begin
          if (good && digit == DIG_D4) begin
            seen_reg  <= 4'b0001;
            state_reg <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          seen_reg <= seen_next;
          if (seen_next == 4'hF) state_reg <= ST_COMPARE;
        end
        ST_COMPARE: begin
          seen_reg  <= seen_strobe;
          state_reg <= ST_COLLECT;
          if (!err_any) begin
            stable_reg <= stable_next;
            prev_reg   <= frame;
            if (stable_next == STABLE_MAX) begin
              value     <= frame;
              valid     <= 1'b1;
              new_value <= !valid || (value != frame);
            end
          end
        end
        default: state_reg <= ST_SYNC;
      endcase

      if (err_any) begin
        state_reg  <= ST_SYNC;
        seen_reg   <= 4'd0;
        stable_reg <= 4'd0;
      end

      if (timeout) begin
        valid      <= 1'b0;
        state_reg  <= ST_SYNC;
        seen_reg   <= 4'd0;
        stable_reg <= 4'd0;
      end
    end
  end

endmodule
